// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared serial link parameters and credit counter type.
package serial_link_pkg;
  localparam int NumCredits = 8;
  typedef logic [$clog2(NumCredits):0] credit_t;
endpackage

// File: rtl/serial_link_credit_ctrl.sv
// serial_link_credit_ctrl: credit-based send flow control with piggybacked credit return.
module serial_link_credit_ctrl #(
  parameter int NumCredits      = serial_link_pkg::NumCredits,
  parameter int ForceSendThresh = NumCredits - 2,
  parameter int DataWidth       = 128
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_out_valid_i,
  output logic                      data_out_ready_o,
  input  logic [DataWidth-1:0]      data_out_i,
  output logic                      data_out_valid_o,
  input  logic                      data_out_ready_i,
  output logic [DataWidth-1:0]      data_out_o,
  output serial_link_pkg::credit_t  data_out_credits_o,
  output logic                      data_out_credit_only_o,
  input  logic                      data_in_valid_i,
  input  serial_link_pkg::credit_t  data_in_credits_i,
  input  logic                      rx_consumed_i,
  output serial_link_pkg::credit_t  credits_avail_o,
  output serial_link_pkg::credit_t  credits_pending_o,
  output logic                      credit_err_o
);
  typedef serial_link_pkg::credit_t credit_t;
  localparam int W = $clog2(NumCredits) + 2;
  typedef logic [W-1:0] cnt_t;
  localparam cnt_t Max = cnt_t'(NumCredits);
  localparam cnt_t Thr = cnt_t'(ForceSendThresh);
  typedef enum logic {LinkSendIdle, LinkSendBusy} state_e;
  state_e state_q, state_d;
  credit_t avail_q, avail_d, pend_q, pend_d, cred_q, cred_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic co_q, co_d, err_q, err_d;
  logic slot_free, data_load, co_load, load;
  cnt_t avail_sum, pend_sum;
  always_comb begin
    slot_free = state_q == LinkSendIdle || data_out_ready_i;
    data_load = slot_free && data_out_valid_i && avail_q != '0;
    // A credit-only packet also breaks the deadlock where both sides wait for credits.
    co_load = slot_free && !data_load && pend_q != '0 &&
              (cnt_t'(pend_q) >= Thr || (data_out_valid_i && avail_q == '0));
    load = data_load || co_load;
    avail_sum = cnt_t'(avail_q) - cnt_t'(data_load) + (data_in_valid_i ? cnt_t'(data_in_credits_i) : '0);
    pend_sum = (load ? '0 : cnt_t'(pend_q)) + cnt_t'(rx_consumed_i);
    avail_d = avail_sum > Max ? credit_t'(Max) : credit_t'(avail_sum);
    pend_d = pend_sum > Max ? credit_t'(Max) : credit_t'(pend_sum);
    err_d = err_q || avail_sum > Max || pend_sum > Max;
    state_d = load ? LinkSendBusy : slot_free ? LinkSendIdle : state_q;
    data_d = load ? (data_load ? data_out_i : '0) : data_q;
    cred_d = load ? pend_q : cred_q;
    co_d = load ? co_load : co_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= LinkSendIdle;
      avail_q <= credit_t'(Max);
      pend_q  <= '0;
      data_q  <= '0;
      cred_q  <= '0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      avail_q <= avail_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      cred_q  <= cred_d;
      co_q    <= co_d;
      err_q   <= err_d;
    end
  end
  assign data_out_ready_o       = data_load;
  assign data_out_valid_o       = state_q == LinkSendBusy;
  assign data_out_o             = data_q;
  assign data_out_credits_o     = cred_q;
  assign data_out_credit_only_o = co_q;
  assign credits_avail_o        = avail_q;
  assign credits_pending_o      = pend_q;
  assign credit_err_o           = err_q;
endmodule

// File: doc/serial_link_credit_ctrl.md
# serial_link_credit_ctrl

Credit-based flow-control stage of the serial link data-link layer, sitting between the protocol layer (packed AXI payloads) and the physical-layer send/receive path. It tracks how many packets the peer can still buffer, blocks sending when none remain, and counts locally consumed RX packets. Those returned credits are piggybacked on outgoing packets, or sent as credit-only packets when no payload is flowing. The output is a registered one-entry slot driven by a `LinkSendIdle`/`LinkSendBusy` state machine.

## Interface
- `NumCredits`, default `serial_link_pkg::NumCredits` (8): peer RX buffer depth; credit counters reset to this value.
- `ForceSendThresh`, default `NumCredits-2` (6): pending-credit level that forces a credit-only packet.
- `DataWidth`, default 128: payload width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `data_out_valid_i` in 1: upstream payload valid.
- `data_out_ready_o` out 1: upstream payload accepted.
- `data_out_i` in DataWidth: upstream payload.
- `data_out_valid_o` out 1: packet valid to PHY.
- `data_out_ready_i` in 1: PHY accepts packet.
- `data_out_o` out DataWidth: registered payload; all-zero for credit-only packets.
- `data_out_credits_o` out `credit_t`: credits returned to peer with this packet.
- `data_out_credit_only_o` out 1: packet carries no payload.
- `data_in_valid_i` in 1: packet received from PHY; always accepted.
- `data_in_credits_i` in `credit_t`: credits returned by peer.
- `rx_consumed_i` in 1: one received payload popped from the local RX FIFO.
- `credits_avail_o` out `credit_t`: current send credits.
- `credits_pending_o` out `credit_t`: credits not yet returned to peer.
- `credit_err_o` out 1: sticky overflow error.

## Operation
- Reset values:
  - `credits_avail` = NumCredits; `credits_pending` = 0.
  - State = `LinkSendIdle`; `data_out_valid_o` = 0.
  - `data_out_o`, `data_out_credits_o` and `data_out_credit_only_o` = 0; `credit_err_o` = 0.
- Slot free (`slot_free`) = `state==LinkSendIdle` or `data_out_ready_i`.
- Data load (`data_load`) = `slot_free` and `data_out_valid_i` and `credits_avail>0`. `data_out_ready_o` equals `data_load`, computed combinationally.
- Credit-only load = `slot_free`, not `data_load`, `credits_pending>0`, and either of:
  - `credits_pending>=ForceSendThresh`;
  - `data_out_valid_i` is high while `credits_avail==0` (deadlock avoidance).
- On any load:
  - Output register captures the payload (or zero), `credits_pending`, and the credit-only flag.
  - State goes to `LinkSendBusy`.
- With `slot_free` and no load, state goes to `LinkSendIdle`.
- In `LinkSendBusy` with `data_out_ready_i` low, all outputs hold.
- Send credits:
  - Next `credits_avail` = `credits_avail` − `data_load` + (`data_in_valid_i` ? `data_in_credits_i` : 0).
  - Computed at width `$clog2(NumCredits)+2`.
  - A result above NumCredits saturates to NumCredits and sets `credit_err_o`.
  - A credit-only load consumes no credit.
- Pending credits:
  - On a load, next `credits_pending` = `rx_consumed_i`.
  - Otherwise it is `credits_pending` + `rx_consumed_i`.
  - Above NumCredits it saturates and sets `credit_err_o`.
- Received credit-only packets only add credits; they are never counted as consumed.
- `credit_err_o` clears only on reset.

## Timing
- Upstream handshake to `data_out_valid_o`: 1 cycle. Back-to-back throughput: 1 packet/cycle while `data_out_ready_i` stays high and credits remain.
- Credits received in cycle N are usable for a load in cycle N+1. A load in cycle N reduces `credits_avail_o` in cycle N+1.
- Same-cycle receive, load and consume all apply together using the formulas above; nothing is lost.
- `data_out_credits_o` is stable while `data_out_valid_o` is high and `data_out_ready_i` is low.
- Reset asserted mid-transfer drops the output slot at the next edge and restores all counters to reset values.

## Test plan
- **Reset:** hold `rst_ni`=0 for 3 cycles → `credits_avail_o`=8, `credits_pending_o`=0, `data_out_valid_o`=0, `credit_err_o`=0.
- **Credit exhaustion:**
  - Stimulus: stream 10 payloads with `data_out_ready_i`=1 and no incoming credits.
  - Required: exactly 8 accepted on consecutive cycles; `data_out_ready_o`=0 after that; `credits_avail_o`=0.
- **Credit return:**
  - Stimulus: in the exhausted state, drive `data_in_valid_i`=1 with `data_in_credits_i`=3.
  - Required: next cycle `credits_avail_o`=3; 3 more payloads pass, then blocked.
- **Piggyback:**
  - Stimulus: pulse `rx_consumed_i` 2 times, then send one payload.
  - Required: that packet has `data_out_credits_o`=2 and credit-only=0; `credits_pending_o`=0 afterwards.
- **Forced credit-only:**
  - Stimulus: no upstream traffic, 6 `rx_consumed_i` pulses.
  - Required: one credit-only packet with credits=6 and payload 0; `credits_avail_o` unchanged.
  - Stimulus: hold `data_out_ready_i`=0 for 4 cycles.
  - Required: outputs stay stable throughout.
- **Overflow error:**
  - Stimulus: from reset, drive `data_in_credits_i`=1 with `data_in_valid_i`.
  - Required: `credits_avail_o` stays 8; `credit_err_o`=1 and remains 1 until reset.
